narrow_pack: RTL

Store-side counterpart of the ALU extend unit: accepts a stream of 32-bit operands, narrows each to a byte or halfword (truncating or saturating), and packs the narrowed elements little-endian into 32-bit words. It sits between the ALU result path and the memory write port. Valid/ready handshakes on both sides; explicit flush emits partial words.

---
 rtl/narrow_pack.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/narrow_pack.sv
// Narrows 32-bit operands to bytes/halfwords and packs them little-endian into 32-bit words.
// Optional saturation is enabled with the NARROW_PACK_SAT_EN macro.
module narrow_pack #(
  parameter logic [7:0] PAD_BYTE = 8'h00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        mode,
  input  logic        sign,
  input  logic [31:0] num,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] packed_word,
  output logic [2:0]  out_bytes,
  output logic        out_sat
);

  logic [31:0] acc_q, acc_d;
  logic [2:0]  byte_cnt_q, byte_cnt_d;
  logic        acc_sat_q, acc_sat_d;
  logic        flush_pending_q, flush_pending_d;
  logic [31:0] packed_q, packed_d;
  logic [2:0]  out_bytes_q, out_bytes_d;
  logic        out_sat_q, out_sat_d;
  logic        out_valid_q, out_valid_d;

  logic [15:0] elem;
  logic        elem_sat;
  logic [2:0]  size;
  logic [2:0]  sum;
  logic        out_free;
  logic        accept;
  logic        service;
  logic [31:0] acc_wr;

  // Replace lanes at and above n with the pad byte.
  function automatic logic [31:0] pad_word(input logic [31:0] w, input logic [2:0] n);
    logic [31:0] r;
    r = w;
    for (int i = 0; i < 4; i++) begin
      if (3'(i) >= n) r[8*i +: 8] = PAD_BYTE;
    end
    return r;
  endfunction

`ifdef NARROW_PACK_SAT_EN
  always_comb begin
    elem     = num[15:0];
    elem_sat = 1'b0;
    if (sign) begin
      if (mode) begin
        if ($signed(num) > 32'sd32767) begin
          elem     = 16'h7fff;
          elem_sat = 1'b1;
        end else if ($signed(num) < -32'sd32768) begin
          elem     = 16'h8000;
          elem_sat = 1'b1;
        end
      end else begin
        if ($signed(num) > 32'sd127) begin
          elem     = 16'h007f;
          elem_sat = 1'b1;
        end else if ($signed(num) < -32'sd128) begin
          elem     = 16'h0080;
          elem_sat = 1'b1;
        end
      end
    end else begin
      if (mode) begin
        if (num > 32'd65535) begin
          elem     = 16'hffff;
          elem_sat = 1'b1;
        end
      end else begin
        if (num > 32'd255) begin
          elem     = 16'h00ff;
          elem_sat = 1'b1;
        end
      end
    end
  end
`else
  logic unused_inputs;
  assign unused_inputs = ^{sign, num[31:16]};
  assign elem          = num[15:0];
  assign elem_sat      = 1'b0;
`endif

  assign size     = mode ? 3'd2 : 3'd1;
  assign sum      = byte_cnt_q + size;
  assign out_free = !out_valid_q || out_ready;
  assign in_ready = !rst && !(flush_pending_q && byte_cnt_q != 3'd0)
                    && (out_free || sum < 3'd4);
  assign accept   = in_valid && in_ready;
  // Input is held off while a non-empty flush is pending, so service never overlaps accept.
  assign service  = flush_pending_q && byte_cnt_q != 3'd0 && out_free;

  always_comb begin
    acc_wr = acc_q;
    case (byte_cnt_q)
      3'd0: begin
        acc_wr[7:0] = elem[7:0];
        if (mode) acc_wr[15:8] = elem[15:8];
      end
      3'd1: begin
        acc_wr[15:8] = elem[7:0];
        if (mode) acc_wr[23:16] = elem[15:8];
      end
      3'd2: begin
        acc_wr[23:16] = elem[7:0];
        if (mode) acc_wr[31:24] = elem[15:8];
      end
      3'd3: acc_wr[31:24] = elem[7:0];
      default: ;
    endcase
  end

  always_comb begin
    acc_d           = acc_q;
    byte_cnt_d      = byte_cnt_q;
    acc_sat_d       = acc_sat_q;
    flush_pending_d = flush_pending_q;
    packed_d        = packed_q;
    out_bytes_d     = out_bytes_q;
    out_sat_d       = out_sat_q;
    out_valid_d     = out_valid_q && !out_ready;

    if (accept) begin
      if (sum < 3'd4) begin
        acc_d      = acc_wr;
        byte_cnt_d = sum;
        acc_sat_d  = acc_sat_q || elem_sat;
      end else if (sum == 3'd4) begin
        packed_d    = acc_wr;
        out_bytes_d = 3'd4;
        out_sat_d   = acc_sat_q || elem_sat;
        out_valid_d = 1'b1;
        acc_d       = 32'h0;
        byte_cnt_d  = 3'd0;
        acc_sat_d   = 1'b0;
      end else begin
        // Halfword straddles the word boundary: ship 3 bytes, restart with the halfword.
        packed_d    = pad_word(acc_q, 3'd3);
        out_bytes_d = 3'd3;
        out_sat_d   = acc_sat_q;
        out_valid_d = 1'b1;
        acc_d       = {16'h0, elem};
        byte_cnt_d  = 3'd2;
        acc_sat_d   = elem_sat;
      end
    end else if (service) begin
      packed_d    = pad_word(acc_q, byte_cnt_q);
      out_bytes_d = byte_cnt_q;
      out_sat_d   = acc_sat_q;
      out_valid_d = 1'b1;
      acc_d       = 32'h0;
      byte_cnt_d  = 3'd0;
      acc_sat_d   = 1'b0;
    end

    if (flush) begin
      flush_pending_d = 1'b1;
    end else if (flush_pending_q && (byte_cnt_q == 3'd0 || service)) begin
      flush_pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q           <= 32'h0;
      byte_cnt_q      <= 3'd0;
      acc_sat_q       <= 1'b0;
      flush_pending_q <= 1'b0;
      packed_q        <= 32'h0;
      out_bytes_q     <= 3'd0;
      out_sat_q       <= 1'b0;
      out_valid_q     <= 1'b0;
    end else begin
      acc_q           <= acc_d;
      byte_cnt_q      <= byte_cnt_d;
      acc_sat_q       <= acc_sat_d;
      flush_pending_q <= flush_pending_d;
      packed_q        <= packed_d;
      out_bytes_q     <= out_bytes_d;
      out_sat_q       <= out_sat_d;
      out_valid_q     <= out_valid_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign packed_word = packed_q;
  assign out_bytes   = out_bytes_q;
  assign out_sat     = out_sat_q;

endmodule
